// File: rtl/mem_pump_sequencer_pkg.sv
// Shared encodings for the single-port RAM pump: phase and port identifiers, legal read-latency range.
package mem_pump_sequencer_pkg;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

endpackage

// File: rtl/mem_pump_sequencer_if.sv
// Request ports A/B plus the RAM macro side of the pump; slave is the pump, master is the surroundings.
interface mem_pump_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic                  a_valid_in;
  logic                  a_ready_out;
  logic                  a_we_in;
  logic [ADDR_WIDTH-1:0] a_addr_in;
  logic [DATA_WIDTH-1:0] a_wrdata_in;
  logic                  a_rdvalid_out;
  logic [DATA_WIDTH-1:0] a_rddata_out;

  logic                  b_valid_in;
  logic                  b_ready_out;
  logic                  b_we_in;
  logic [ADDR_WIDTH-1:0] b_addr_in;
  logic [DATA_WIDTH-1:0] b_wrdata_in;
  logic                  b_rdvalid_out;
  logic [DATA_WIDTH-1:0] b_rddata_out;

  logic                  ram_en_out;
  logic                  ram_we_out;
  logic [ADDR_WIDTH-1:0] ram_addr_out;
  logic [DATA_WIDTH-1:0] ram_wrdata_out;
  logic [DATA_WIDTH-1:0] ram_rddata_in;
  logic                  latch_en_out;

  modport slave (
    input  a_valid_in, a_we_in, a_addr_in, a_wrdata_in,
    input  b_valid_in, b_we_in, b_addr_in, b_wrdata_in,
    input  ram_rddata_in,
    output a_ready_out, a_rdvalid_out, a_rddata_out,
    output b_ready_out, b_rdvalid_out, b_rddata_out,
    output ram_en_out, ram_we_out, ram_addr_out, ram_wrdata_out,
    output latch_en_out
  );

  modport master (
    output a_valid_in, a_we_in, a_addr_in, a_wrdata_in,
    output b_valid_in, b_we_in, b_addr_in, b_wrdata_in,
    output ram_rddata_in,
    input  a_ready_out, a_rdvalid_out, a_rddata_out,
    input  b_ready_out, b_rdvalid_out, b_rddata_out,
    input  ram_en_out, ram_we_out, ram_addr_out, ram_wrdata_out,
    input  latch_en_out
  );

endinterface

// File: rtl/mem_pump_rdtrack.sv
// Tags each issued read, lines it up with RAM data RD_LATENCY clocks later, and captures it into the
// issuing port's hold register with a one-cycle rdvalid pulse; reset drops every read in flight.
module mem_pump_rdtrack
  import mem_pump_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  i_issue_rd,
  input  logic                  i_issue_port,
  input  logic [DATA_WIDTH-1:0] i_ram_rddata,
  output logic                  o_a_rdvalid,
  output logic [DATA_WIDTH-1:0] o_a_rddata,
  output logic                  o_b_rdvalid,
  output logic [DATA_WIDTH-1:0] o_b_rddata
);

  logic [RD_LATENCY-1:0] r_sr_vld;
  logic [RD_LATENCY-1:0] r_sr_port;
  logic                  r_a_rdvalid;
  logic                  r_b_rdvalid;
  logic [DATA_WIDTH-1:0] r_a_rddata;
  logic [DATA_WIDTH-1:0] r_b_rddata;
  logic                  w_ret_a;
  logic                  w_ret_b;

  assign w_ret_a = r_sr_vld[RD_LATENCY-1] & (r_sr_port[RD_LATENCY-1] == PORT_A);
  assign w_ret_b = r_sr_vld[RD_LATENCY-1] & (r_sr_port[RD_LATENCY-1] == PORT_B);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_sr_vld    <= '0;
      r_sr_port   <= '0;
      r_a_rdvalid <= 1'b0;
      r_b_rdvalid <= 1'b0;
      r_a_rddata  <= '0;
      r_b_rddata  <= '0;
    end else begin
      r_sr_vld[0]  <= i_issue_rd;
      r_sr_port[0] <= i_issue_port;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_sr_vld[i]  <= r_sr_vld[i-1];
        r_sr_port[i] <= r_sr_port[i-1];
      end
      r_a_rdvalid <= w_ret_a;
      r_b_rdvalid <= w_ret_b;
      // Each hold register moves only on its own port's return.
      if (w_ret_a) r_a_rddata <= i_ram_rddata;
      if (w_ret_b) r_b_rddata <= i_ram_rddata;
    end
  end

  assign o_a_rdvalid = r_a_rdvalid;
  assign o_b_rdvalid = r_b_rdvalid;
  assign o_a_rddata  = r_a_rddata;
  assign o_b_rddata  = r_b_rddata;

endmodule

// File: rtl/mem_pump_sequencer.sv
// Time-slices one single-port RAM between ports A and B in fixed alternating phases (no phase donation),
// registering the RAM strobes and steering read returns back to the issuing port.
module mem_pump_sequencer
  import mem_pump_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic             clock_in,
  input  logic             reset_in,
  mem_pump_sequencer_if.slave pump
);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("mem_pump_sequencer: RD_LATENCY out of range");
  end

  phase_e                r_phase;
  phase_e                w_phase_nxt;
  logic                  w_acc_a;
  logic                  w_acc_b;
  logic                  r_ram_en;
  logic                  r_ram_we;
  logic                  r_ram_port;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wrdata;
  logic                  w_a_rdvalid;
  logic                  w_b_rdvalid;
  logic [DATA_WIDTH-1:0] w_a_rddata;
  logic [DATA_WIDTH-1:0] w_b_rddata;

  always_ff @(posedge clock_in) begin
    if (reset_in) r_phase <= PH_A;
    else          r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = (r_phase == PH_A) ? PH_B : PH_A;
  end

  // Ready is pure phase gating so each port sees fixed, traffic-independent timing.
  always_comb begin
    w_acc_a = 1'b0;
    w_acc_b = 1'b0;
    if (!reset_in) begin
      case (r_phase)
        PH_A:    w_acc_a = pump.a_valid_in;
        PH_B:    w_acc_b = pump.b_valid_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_port   <= PORT_A;
      r_ram_addr   <= '0;
      r_ram_wrdata <= '0;
    end else begin
      r_ram_en   <= w_acc_a | w_acc_b;
      r_ram_we   <= (w_acc_a & pump.a_we_in) | (w_acc_b & pump.b_we_in);
      r_ram_port <= w_acc_b ? PORT_B : PORT_A;
      if (w_acc_a) begin
        r_ram_addr   <= pump.a_addr_in;
        r_ram_wrdata <= pump.a_wrdata_in;
      end else if (w_acc_b) begin
        r_ram_addr   <= pump.b_addr_in;
        r_ram_wrdata <= pump.b_wrdata_in;
      end
    end
  end

  mem_pump_rdtrack #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rdtrack (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .i_issue_rd   (r_ram_en & ~r_ram_we),
    .i_issue_port (r_ram_port),
    .i_ram_rddata (pump.ram_rddata_in),
    .o_a_rdvalid  (w_a_rdvalid),
    .o_a_rddata   (w_a_rddata),
    .o_b_rdvalid  (w_b_rdvalid),
    .o_b_rddata   (w_b_rddata)
  );

  assign pump.a_ready_out    = w_acc_a;
  assign pump.b_ready_out    = w_acc_b;
  assign pump.ram_en_out     = r_ram_en;
  assign pump.ram_we_out     = r_ram_we;
  assign pump.ram_addr_out   = r_ram_addr;
  assign pump.ram_wrdata_out = r_ram_wrdata;
  assign pump.a_rdvalid_out  = w_a_rdvalid;
  assign pump.b_rdvalid_out  = w_b_rdvalid;
  assign pump.a_rddata_out   = w_a_rddata;
  assign pump.b_rddata_out   = w_b_rddata;
  assign pump.latch_en_out   = w_a_rdvalid | w_b_rdvalid;

endmodule

// File: tb/tb_mem_pump_sequencer.sv
// Bench for mem_pump_sequencer: a RAM macro with RD_LATENCY read delay plus a transaction-level model
// (phase = cycle parity, per-port expected-return queues, flat memory array).
module tb_mem_pump_sequencer;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_pump_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_pump_sequencer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (LAT)
  ) dut (
    .clock_in (clk),
    .reset_in (rst),
    .pump     (bus)
  );

  // RAM macro: unwritten words read back as addr*3.
  logic [DW-1:0]   ram [1024];
  logic [1023:0]   ram_wr = '0;
  logic [DW-1:0]   ram_pipe [LAT];

  always @(posedge clk) begin
    if (bus.ram_en_out && bus.ram_we_out) begin
      ram[bus.ram_addr_out]    <= bus.ram_wrdata_out;
      ram_wr[bus.ram_addr_out] <= 1'b1;
    end
    if (bus.ram_en_out && !bus.ram_we_out)
      ram_pipe[0] <= ram_wr[bus.ram_addr_out] ? ram[bus.ram_addr_out] : DW'(32'(bus.ram_addr_out) * 3);
    else
      ram_pipe[0] <= 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bus.ram_rddata_in = ram_pipe[LAT-1];

  typedef struct packed {
    int          due;
    logic [DW-1:0] dat;
  } rd_t;

  logic [DW-1:0] mmem [1024];
  rd_t           qa[$];
  rd_t           qb[$];
  logic [DW-1:0] ha, hb;
  logic          exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;
  int            cyc;
  int            n_total = 0;
  int            n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    bus.a_valid_in = av; bus.a_we_in = aw; bus.a_addr_in = aa; bus.a_wrdata_in = ad;
    bus.b_valid_in = bv; bus.b_we_in = bw; bus.b_addr_in = ba; bus.b_wrdata_in = bd;
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete();
    ha = '0; hb = '0;
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    cyc = 0;
  endtask

  task automatic step(input logic av, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    logic ev_a, ev_b, ra, rb;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(av, aw, aa, ad, bv, bw, ba, bd);
    @(negedge clk);
    ev_a = (qa.size() > 0) && (qa[0].due == cyc);
    ev_b = (qb.size() > 0) && (qb[0].due == cyc);
    if (ev_a) ha = qa.pop_front().dat;
    if (ev_b) hb = qb.pop_front().dat;
    ra = av && (cyc % 2 == 0);
    rb = bv && (cyc % 2 == 1);
    chk("a_ready",  bus.a_ready_out,    ra);
    chk("b_ready",  bus.b_ready_out,    rb);
    chk("a_rdvld",  bus.a_rdvalid_out,  ev_a);
    chk("b_rdvld",  bus.b_rdvalid_out,  ev_b);
    chk("latch_en", bus.latch_en_out,   ev_a | ev_b);
    chk("a_rddata", bus.a_rddata_out,   ha);
    chk("b_rddata", bus.b_rddata_out,   hb);
    chk("ram_en",   bus.ram_en_out,     exp_en);
    chk("ram_we",   bus.ram_we_out,     exp_we);
    chk("ram_addr", bus.ram_addr_out,   exp_addr);
    chk("ram_wd",   bus.ram_wrdata_out, exp_wd);
    exp_en = ra | rb;
    exp_we = (ra & aw) | (rb & bw);
    if (ra) begin
      exp_addr = aa; exp_wd = ad;
      if (aw) mmem[aa] = ad;
      else    qa.push_back('{due: cyc + LAT + 2, dat: mmem[aa]});
    end
    if (rb) begin
      exp_addr = ba; exp_wd = bd;
      if (bw) mmem[ba] = bd;
      else    qb.push_back('{due: cyc + LAT + 2, dat: mmem[ba]});
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic align_a();
    if (cyc % 2 != 0) idle(1);
  endtask

  // full=0: the first cycle still shows pre-reset register state, so only ready is checked there.
  task automatic do_reset(input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1, $urandom_range(0, 1), AW'($urandom), $urandom, 1, $urandom_range(0, 1), AW'($urandom), $urandom);
      @(negedge clk);
      chk("rst_a_ready", bus.a_ready_out, 0);
      chk("rst_b_ready", bus.b_ready_out, 0);
      if (full || i > 0) begin
        chk("rst_ram_en",   bus.ram_en_out,     0);
        chk("rst_ram_we",   bus.ram_we_out,     0);
        chk("rst_ram_addr", bus.ram_addr_out,   0);
        chk("rst_ram_wd",   bus.ram_wrdata_out, 0);
        chk("rst_a_rdvld",  bus.a_rdvalid_out,  0);
        chk("rst_b_rdvld",  bus.b_rdvalid_out,  0);
        chk("rst_a_rddata", bus.a_rddata_out,   0);
        chk("rst_b_rddata", bus.b_rddata_out,   0);
        chk("rst_latch_en", bus.latch_en_out,   0);
      end
    end
    model_clear();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mmem[i] = DW'(i * 3);
    model_clear();
    rst = 1'b1;
    drive(1, 0, '0, '0, 1, 0, '0, '0);
    @(posedge clk);
    do_reset(3, 1'b1);

    // Write A then read B of the same address in the adjacent phase.
    step(1, 1, 10'd5, 32'h1122_3344, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 0, 10'd5, '0);
    idle(6);
    chk("wr_rd_b_data", bus.b_rddata_out, 32'h1122_3344);

    // Interleaved continuous reads A 1..3 / B 10..12.
    align_a();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, AW'(1 + i), '0, 0, 0, '0, '0);
      step(0, 0, '0, '0, 1, 0, AW'(10 + i), '0);
    end
    idle(6);
    chk("ilv_a_last", bus.a_rddata_out, 32'd9);
    chk("ilv_b_last", bus.b_rddata_out, 32'd36);

    // Only A valid, held for 8 cycles.
    for (int i = 0; i < 8; i++) step(1, 0, 10'd7, '0, 0, 0, '0, '0);
    idle(6);

    // A captures 0xAAAA, then B reads must not disturb it.
    align_a();
    step(1, 1, 10'd20, 32'h0000_AAAA, 0, 0, '0, '0);
    idle(1);
    step(1, 0, 10'd20, '0, 0, 0, '0, '0);
    idle(5);
    for (int i = 0; i < 6; i++) step(0, 0, '0, '0, 1, 0, AW'(30 + i), '0);
    idle(6);
    chk("hold_a", bus.a_rddata_out, 32'h0000_AAAA);

    // Reset right after a read accept discards it.
    align_a();
    step(1, 0, 10'd5, '0, 0, 0, '0, '0);
    do_reset(2, 1'b0);
    idle(6);

    // Random traffic on a small address window to exercise hazards.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom);
    idle(6);
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_pump_sequencer.md
Name: mem_pump_sequencer

Overview:
- Drives one physical single-port RAM from two logical request ports (A, B), issued in strict alternating phases.
- Steers each read return to the port that issued it, and holds that data stable until the port's next read returns.
- Sits between the pcore/dataplane request logic and a RAM macro. It is the issuing and driving end of the stable-data capture scheme used to overclock memory blocks for better utilisation.

Parameters:
DATA_WIDTH, 32, RAM word width
ADDR_WIDTH, 10, RAM address width
RD_LATENCY, 2, RAM read latency in clocks from issue to ram_rddata_in valid (range 1..4)

Ports:
clock_in  in  1  single clock; all state updates on rising edge
reset_in  in  1  synchronous, active-high reset
a_valid_in  in  1  port A request valid
a_ready_out  out  1  port A request accepted this cycle
a_we_in  in  1  port A write (1) / read (0)
a_addr_in  in  ADDR_WIDTH  port A address
a_wrdata_in  in  DATA_WIDTH  port A write data
a_rdvalid_out  out  1  one-cycle pulse, port A read data updated
a_rddata_out  out  DATA_WIDTH  port A read data, held between pulses
b_*  (same seven ports for port B)
ram_en_out  out  1  RAM access strobe
ram_we_out  out  1  RAM write enable
ram_addr_out  out  ADDR_WIDTH  RAM address
ram_wrdata_out  out  DATA_WIDTH  RAM write data
ram_rddata_in  in  DATA_WIDTH  RAM read data, valid RD_LATENCY clocks after a read issue
latch_en_out  out  1  capture strobe for downstream stable-data holders; equals a_rdvalid_out OR b_rdvalid_out

Behaviour:
- Reset (reset_in=1 at a clock edge):
  - phase=PH_A; pipeline tags cleared.
  - All *_ready_out, *_rdvalid_out, ram_en_out, ram_we_out, latch_en_out = 0.
  - ram_addr_out, ram_wrdata_out, a_rddata_out, b_rddata_out = 0.
- Phase FSM, two states, toggles every non-reset cycle regardless of traffic: PH_A -> PH_B -> PH_A.
- Issue, PH_A:
  - a_ready_out = a_valid_in (combinational).
  - If a_valid_in: ram_en_out=1, ram_we_out=a_we_in, address/data taken from port A, registered so the RAM sees them the next cycle.
  - b_ready_out=0.
- Issue, PH_B: mirror of PH_A for port B.
- An idle phase is not donated to the other port. Fixed 50% bandwidth per port; deterministic timing is required.
- Request handshake: a request transfers when valid & ready. Request fields need only be stable in the accepted cycle. A port whose valid is held waits at most 1 cycle for its phase.
- Registered RAM outputs: ram_en_out/ram_we_out/ram_addr_out/ram_wrdata_out update one cycle after acceptance. ram_en_out=0 on idle phases; addr/wrdata then hold their last value.
- Read tracking:
  - Shift register of depth RD_LATENCY carries {read_issued, port_id}, advanced every cycle.
  - When the tail shows read_issued, ram_rddata_in is captured into the tagged port's rddata register.
  - That port's rdvalid pulses for exactly one cycle, aligned with the updated data (registered capture).
- Writes produce no response.
- Total read latency: acceptance -> rdvalid = 1 (issue register) + RD_LATENCY + 1 (capture) clocks.
- Hold: *_rddata_out changes only on that port's rdvalid pulse. It is never disturbed by the other port's returns or by writes.
- Same-address hazard: a write from one port and a read from the other in adjacent phases are serviced in issue order. The read returns the RAM's behaviour for that order; no forwarding.
- Back-to-back reads A,B,A,B give alternating rdvalid pulses, one per cycle, with latch_en_out high continuously.
- Reset mid-operation: in-flight reads are discarded. No rdvalid is produced for any read issued before reset. Held rddata clears to 0.

Decomposition:
- Shared package:
  - phase encoding constants PH_A=0, PH_B=1
  - port-id constants PORT_A=0, PORT_B=1
  - the RD_LATENCY legal-range limits
- One natural sub-module: mem_pump_rdtrack (tag shift register plus per-port capture/hold registers and rdvalid generation), parameterised by DATA_WIDTH and RD_LATENCY.

Test Plan:
- Reset with both valids high -> all outputs 0 during reset. First cycle after release is PH_A with a_ready_out=1 and b_ready_out=0.
- Write A addr=5 data=0x11223344, then read B addr=5 (RD_LATENCY=2) -> b_rdvalid_out pulses 4 clocks after B accept with b_rddata_out=0x11223344. a_rdvalid_out never pulses.
- Continuous reads A addr 1,2,3 interleaved with B addr 10,11,12 (RAM preloaded word=addr*3) -> rdvalid alternates A,B every cycle. A data 3,6,9; B data 30,33,36; latch_en_out high for 6 consecutive cycles.
- Only A valid held high for 8 cycles -> accepted on PH_A cycles only (4 accepts). ram_en_out=0 on PH_B-derived cycles. b_rddata_out unchanged.
- Read A returns 0xAAAA, then B issues 3 reads -> a_rddata_out stays 0xAAAA throughout.
- Reset asserted 1 cycle after a read accept -> no rdvalid in the following 6 cycles; a_rddata_out=0.
